// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the write-back front end.
package mips_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  rnum;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot mask for a register; register 0 maps to an empty mask so it is never tracked.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_W-1:0] r);
        reg_mask = '0;
        if (r != REG_ZERO) begin
            reg_mask[r] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of pending long-latency write-back results.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_data,
    input  logic          pop,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-file write front end: merges ALU and long-latency results onto one
// write port and tracks outstanding long destinations to stall hazardous issues.
module wb_scoreboard
    import mips_pkg::*;
#(
    parameter int NREGS  = NUM_REGS,
    parameter int AW     = REG_W,
    parameter int DW     = DATA_W,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_long,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    issue_rs,
    input  logic [AW-1:0]    issue_rt,
    output logic             stall,
    input  logic             alu_wb_valid,
    input  logic [AW-1:0]    alu_wb_reg,
    input  logic [DW-1:0]    alu_wb_data,
    input  logic             long_wb_valid,
    input  logic [AW-1:0]    long_wb_reg,
    input  logic [DW-1:0]    long_wb_data,
    output logic             long_wb_ready,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [NREGS-1:0] pending,
    output logic [AW-1:0]    q_count
);

    localparam int CW = $clog2(QDEPTH) + 1;

    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic          q_full;
    logic          q_empty;
    logic          q_pop;
    logic [CW-1:0] fifo_count;
    logic          sel_we;
    logic [AW-1:0] sel_reg;
    logic [DW-1:0] sel_data;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    assign push_entry    = '{rnum: long_wb_reg, data: long_wb_data};
    assign long_wb_ready = !q_full;
    assign q_pop         = !alu_wb_valid && !q_empty;
    assign q_count       = AW'(fifo_count);

    wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (long_wb_valid),
        .push_data (push_entry),
        .pop       (q_pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (fifo_count)
    );

    always_comb begin
        stall = 1'b0;
        if (issue_valid) begin
            stall = (issue_rs != REG_ZERO && pending[issue_rs])
                 || (issue_rt != REG_ZERO && pending[issue_rt])
                 || (issue_rd != REG_ZERO && pending[issue_rd]);
        end
    end

    // ALU has strict priority; the queue head only drains on ALU-idle cycles.
    always_comb begin
        sel_we   = 1'b0;
        sel_reg  = '0;
        sel_data = '0;
        set_mask = '0;
        clr_mask = '0;
        if (alu_wb_valid) begin
            sel_we   = (alu_wb_reg != REG_ZERO);
            sel_reg  = alu_wb_reg;
            sel_data = alu_wb_data;
        end else if (q_pop) begin
            sel_we   = (head.rnum != REG_ZERO);
            sel_reg  = head.rnum;
            sel_data = head.data;
            clr_mask = reg_mask(head.rnum);
        end
        if (issue_valid && !stall && issue_long) begin
            set_mask = reg_mask(issue_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pending  <= '0;
        end else begin
            rf_we    <= sel_we;
            rf_waddr <= sel_reg;
            rf_wdata <= sel_data;
            pending  <= (pending & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard with a queue-based reference model checked every cycle.
module tb_wb_scoreboard;
    import mips_pkg::*;

    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd, issue_rs, issue_rt;
    logic        stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_reg;
    logic [31:0] alu_wb_data;
    logic        long_wb_valid;
    logic [4:0]  long_wb_reg;
    logic [31:0] long_wb_data;
    logic        long_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic [4:0]  q_count;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model: pending bits, a FIFO of results, and the expected write port.
    logic [31:0] m_pending;
    logic [4:0]  mq_reg[$];
    logic [31:0] mq_data[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [4:0]  m_pr;
    logic [31:0] m_pd;
    bit          m_popped, m_full, m_stall;

    always #5 clk = ~clk;

    wb_scoreboard #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .stall(stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
        .long_wb_valid(long_wb_valid), .long_wb_reg(long_wb_reg), .long_wb_data(long_wb_data),
        .long_wb_ready(long_wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .q_count(q_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit model_stall();
        return issue_valid && ((issue_rs != 0 && m_pending[issue_rs])
                            || (issue_rt != 0 && m_pending[issue_rt])
                            || (issue_rd != 0 && m_pending[issue_rd]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending = '0;
            mq_reg.delete();
            mq_data.delete();
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            m_stall  = model_stall();
            m_full   = (mq_reg.size() == QDEPTH);
            m_popped = 1'b0;
            if (alu_wb_valid) begin
                m_we = (alu_wb_reg != 0); m_waddr = alu_wb_reg; m_wdata = alu_wb_data;
            end else if (mq_reg.size() > 0) begin
                m_pr = mq_reg.pop_front();
                m_pd = mq_data.pop_front();
                m_popped = 1'b1;
                m_we = (m_pr != 0); m_waddr = m_pr; m_wdata = m_pd;
            end else begin
                m_we = 1'b0;
            end
            if (long_wb_valid && !m_full) begin
                mq_reg.push_back(long_wb_reg);
                mq_data.push_back(long_wb_data);
            end
            if (m_popped) m_pending[m_pr] = 1'b0;
            if (issue_valid && !m_stall && issue_long && issue_rd != 0) m_pending[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            checkOutput("cyc_stall", 32'(stall), 32'(model_stall()));
            checkOutput("cyc_ready", 32'(long_wb_ready), 32'(mq_reg.size() < QDEPTH));
            checkOutput("cyc_rf_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
                checkOutput("cyc_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                checkOutput("cyc_rf_wdata", rf_wdata, m_wdata);
            end
            checkOutput("cyc_pending", pending, m_pending);
            checkOutput("cyc_q_count", 32'(q_count), 32'(mq_reg.size()));
        end
    end

    task automatic applyStimulus(input bit iv, input bit il, input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input bit av, input logic [4:0] ar,
                                 input logic [31:0] ad, input bit lv, input logic [4:0] lr,
                                 input logic [31:0] ld);
        issue_valid = iv; issue_long = il; issue_rd = rd; issue_rs = rs; issue_rt = rt;
        alu_wb_valid = av; alu_wb_reg = ar; alu_wb_data = ad;
        long_wb_valid = lv; long_wb_reg = lr; long_wb_data = ld;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        idle();
        step();
        step();
        checkOutput("rst_rf_we", 32'(rf_we), 0);
        checkOutput("rst_rf_waddr", 32'(rf_waddr), 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_q_count", 32'(q_count), 0);
        checkOutput("rst_ready", 32'(long_wb_ready), 1);
        rst = 1'b0;
        check_en = 1'b1;

        $display("[TB] reset mid-traffic");
        applyStimulus(1, 1, 8, 0, 0, 1, 3, 32'h33, 0, 0, 0); step();
        applyStimulus(1, 1, 9, 0, 0, 1, 3, 32'h34, 0, 0, 0); step();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h35, 1, 8, 32'h11); step();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h36, 1, 9, 32'h22); step();
        checkOutput("t1_pending", pending, 32'h0000_0300);
        checkOutput("t1_q_count", 32'(q_count), 2);
        idle();
        rst = 1'b1;
        #1;
        checkOutput("t1_async_rf_we", 32'(rf_we), 0);
        checkOutput("t1_async_pending", pending, 0);
        checkOutput("t1_async_q_count", 32'(q_count), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t1_no_stale_we", 32'(rf_we), 0);
        end

        $display("[TB] RAW hazard");
        applyStimulus(1, 1, 8, 2, 3, 0, 0, 0, 0, 0, 0); step();
        applyStimulus(1, 0, 20, 8, 1, 0, 0, 0, 1, 8, 32'hDEADBEEF); #1;
        checkOutput("t2_stall_raw", 32'(stall), 1);
        step();
        applyStimulus(1, 0, 20, 8, 1, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("t2_stall_queued", 32'(stall), 1);
        step();
        checkOutput("t2_rf_we", 32'(rf_we), 1);
        checkOutput("t2_rf_waddr", 32'(rf_waddr), 8);
        checkOutput("t2_rf_wdata", rf_wdata, 32'hDEADBEEF);
        checkOutput("t2_pending8", 32'(pending[8]), 0);
        #1;
        checkOutput("t2_stall_released", 32'(stall), 0);
        step();
        idle(); step();

        $display("[TB] ALU priority");
        applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0); step();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'hA, 1, 9, 32'h1); step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_alu_waddr", 32'(rf_waddr), 3);
            checkOutput("t3_alu_wdata", rf_wdata, 32'hA);
            checkOutput("t3_pending9_held", 32'(pending[9]), 1);
            if (i < 2) begin
                applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'hA, 0, 0, 0);
            end else begin
                idle();
            end
            step();
        end
        checkOutput("t3_long_waddr", 32'(rf_waddr), 9);
        checkOutput("t3_long_wdata", rf_wdata, 32'h1);
        checkOutput("t3_pending9_clear", 32'(pending[9]), 0);

        $display("[TB] full queue");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 5'(10 + i), 0, 0, 0, 0, 0, 0, 0, 0); step();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i)); step();
        end
        checkOutput("t4_q_full_count", 32'(q_count), 4);
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h9, 1, 14, 32'h104); #1;
        checkOutput("t4_ready_full", 32'(long_wb_ready), 0);
        step();
        checkOutput("t4_held_count", 32'(q_count), 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 32'h104); #1;
        checkOutput("t4_ready_full_pop", 32'(long_wb_ready), 0);
        step();
        checkOutput("t4_ready_after_pop", 32'(long_wb_ready), 1);
        checkOutput("t4_q_after_pop", 32'(q_count), 3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_order_waddr", 32'(rf_waddr), 32'(10 + i));
            checkOutput("t4_order_wdata", rf_wdata, 32'h100 + 32'(i));
            if (i == 0) idle();
            if (i == 0) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 32'h104);
            if (i == 1) idle();
            if (i < 4) step();
        end
        checkOutput("t4_q_drained", 32'(q_count), 0);
        checkOutput("t4_pending_clear", pending, 0);

        $display("[TB] register zero");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("t5_stall_rd0", 32'(stall), 0);
        step();
        checkOutput("t5_pending_rd0", pending, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h5, 0, 0, 0); step();
        checkOutput("t5_rf_we_reg0", 32'(rf_we), 0);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0); step();
        applyStimulus(1, 0, 6, 0, 0, 0, 0, 0, 1, 5, 32'h55); #1;
        checkOutput("t5_stall_rs0", 32'(stall), 0);
        step();
        idle(); step();
        checkOutput("t5_pending_clean", pending, 0);

        $display("[TB] WAW hazard");
        applyStimulus(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0); step();
        applyStimulus(1, 1, 12, 1, 2, 0, 0, 0, 1, 12, 32'h00C0FFEE); #1;
        checkOutput("t6_stall_waw", 32'(stall), 1);
        step();
        applyStimulus(1, 1, 12, 1, 2, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("t6_stall_hold", 32'(stall), 1);
        n = 0;
        while (stall === 1'b1 && n < 10) begin
            step();
            n++;
        end
        checkOutput("t6_stall_drop", 32'(stall), 0);
        checkOutput("t6_wait_cycles", 32'(n), 1);
        checkOutput("t6_old_waddr", 32'(rf_waddr), 12);
        checkOutput("t6_old_wdata", rf_wdata, 32'h00C0FFEE);
        step();
        checkOutput("t6_pending12_reset", 32'(pending[12]), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hBEEF); step();
        idle(); step();
        checkOutput("t6_pending_clean", pending, 0);
        step(); step();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
